// File: rtl/bcast_fanout.sv
// bcast_fanout -- downward half of the MPI collective tree.
//
// Accepts one collective flit (reduction result or root broadcast), hands an
// unchanged copy to the local host, then emits one re-addressed copy per tree
// child (dst = neighbour coordinate, src = this rank), one per handshake.
//
// Optional feature macro: BCAST_DUP_FILTER_EN
//   When defined, a valid flit whose {contextId,tag} matches the last accepted
//   valid flit's key is consumed and dropped without any copies.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   in_flit/in_valid/in_ready           incoming flit handshake
//   child_mask         child directions (0 +x,1 -x,2 +y,3 -y,4 +z,5 -z),
//                      sampled with in_flit
//   local_flit/local_valid/local_ready  host copy handshake
//   out_flit/out_valid/out_ready        network copy handshake
//   busy               block is not idle
//   copies_sent        completed out handshakes (wraps)
//
// Flit fields: valid 72 | dst z,y,x 71:63 | src z,y,x 62:54 | contextId 53:46
//              | tag 45:38 | algtype 37:36 | op 35:32 | payload 31:0
module bcast_fanout #(
    parameter logic [2:0] RANK_X    = 3'd0,
    parameter logic [2:0] RANK_Y    = 3'd0,
    parameter logic [2:0] RANK_Z    = 3'd0,
    parameter int         FlitWidth = 73
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [FlitWidth-1:0] in_flit,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [5:0]           child_mask,
    output logic [FlitWidth-1:0] local_flit,
    output logic                 local_valid,
    input  logic                 local_ready,
    output logic [FlitWidth-1:0] out_flit,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic [15:0]          copies_sent
);

    typedef enum logic [1:0] {IDLE, LOCAL, SEND} state_t;

    state_t               state;
    logic [FlitWidth-1:0] hold_flit;
    logic [5:0]           pending;
    logic [5:0]           pending_clr;
    logic                 dup;

    // Isolate the lowest set bit; directions are served in bit order.
    function automatic logic [5:0] lowest(input logic [5:0] p);
        return p & (~p + 6'd1);
    endfunction

    // Build the child copy for a one-hot direction. Axes wrap modulo 8.
    function automatic logic [FlitWidth-1:0] make_copy(input logic [FlitWidth-1:0] f,
                                                       input logic [5:0] oh);
        logic [FlitWidth-1:0] r;
        logic [2:0] x, y, z;
        x = RANK_X;
        y = RANK_Y;
        z = RANK_Z;
        if (oh[0]) x = RANK_X + 3'd1;
        if (oh[1]) x = RANK_X - 3'd1;
        if (oh[2]) y = RANK_Y + 3'd1;
        if (oh[3]) y = RANK_Y - 3'd1;
        if (oh[4]) z = RANK_Z + 3'd1;
        if (oh[5]) z = RANK_Z - 3'd1;
        r        = f;
        r[72]    = 1'b1;
        r[71:63] = {z, y, x};
        r[62:54] = {RANK_Z, RANK_Y, RANK_X};
        return r;
    endfunction

    assign pending_clr = pending & ~lowest(pending);

`ifdef BCAST_DUP_FILTER_EN
    logic [15:0] last_key;
    logic        key_valid;

    always_comb begin
        dup = key_valid && ({in_flit[53:46], in_flit[45:38]} == last_key);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_key  <= '0;
            key_valid <= 1'b0;
        end else if (state == IDLE && in_valid && in_flit[72]) begin
            last_key  <= {in_flit[53:46], in_flit[45:38]};
            key_valid <= 1'b1;
        end
    end
`else
    always_comb begin
        dup = 1'b0;
    end
`endif

    // in_ready depends only on state and reset, never on in_* inputs.
    assign in_ready = (state == IDLE) && !rst;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            hold_flit   <= '0;
            pending     <= '0;
            local_flit  <= '0;
            local_valid <= 1'b0;
            out_flit    <= '0;
            out_valid   <= 1'b0;
            copies_sent <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Invalid or duplicate flits are consumed and dropped here.
                    if (in_valid && in_flit[72] && !dup) begin
                        hold_flit   <= in_flit;
                        pending     <= child_mask;
                        local_flit  <= in_flit;
                        local_valid <= 1'b1;
                        state       <= LOCAL;
                    end
                end
                LOCAL: begin
                    if (local_ready) begin
                        local_valid <= 1'b0;
                        local_flit  <= '0;
                        if (pending != 6'd0) begin
                            out_valid <= 1'b1;
                            out_flit  <= make_copy(hold_flit, lowest(pending));
                            state     <= SEND;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        pending     <= pending_clr;
                        copies_sent <= copies_sent + 16'd1;
                        // Next copy is prepared at the handshake edge so it
                        // appears the following cycle with no bubble.
                        if (pending_clr != 6'd0) begin
                            out_flit <= make_copy(hold_flit, lowest(pending_clr));
                        end else begin
                            out_flit  <= '0;
                            out_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcast_fanout.sv
// Testbench for bcast_fanout: two instances at ranks (1,1,1) and (7,0,0)
// share all inputs; a direction-list reference model predicts each copy.
module tb_bcast_fanout;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [72:0] in_flit = '0;
    logic        in_valid = 1'b0;
    logic [5:0]  child_mask = '0;
    logic        local_ready = 1'b1;
    logic        out_ready = 1'b1;

    logic [72:0] lf [2];
    logic [72:0] of [2];
    logic        lv [2];
    logic        ov [2];
    logic        ir [2];
    logic        bz [2];
    logic [15:0] cs [2];

    int checks = 0;
    int errors = 0;

    // Model state
    int          rkx [2] = '{1, 7};
    int          rky [2] = '{1, 0};
    int          rkz [2] = '{1, 0};
    logic [15:0] cnt = '0;
    logic [15:0] mkey = '0;
    bit          mkey_v = 1'b0;

    always #5 clk = ~clk;

    bcast_fanout #(.RANK_X(3'd1), .RANK_Y(3'd1), .RANK_Z(3'd1), .FlitWidth(73)) u_a (
        .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid), .in_ready(ir[0]),
        .child_mask(child_mask), .local_flit(lf[0]), .local_valid(lv[0]),
        .local_ready(local_ready), .out_flit(of[0]), .out_valid(ov[0]),
        .out_ready(out_ready), .busy(bz[0]), .copies_sent(cs[0])
    );

    bcast_fanout #(.RANK_X(3'd7), .RANK_Y(3'd0), .RANK_Z(3'd0), .FlitWidth(73)) u_b (
        .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid), .in_ready(ir[1]),
        .child_mask(child_mask), .local_flit(lf[1]), .local_valid(lv[1]),
        .local_ready(local_ready), .out_flit(of[1]), .out_valid(ov[1]),
        .out_ready(out_ready), .busy(bz[1]), .copies_sent(cs[1])
    );

    task automatic chk(input string tag, input int d, input logic [72:0] obs, input logic [72:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, obs, exp);
        end
    endtask

    // Copy toward direction dir as seen from instance d.
    function automatic logic [72:0] mcopy(input logic [72:0] f, input int dir, input int d);
        logic [72:0] r;
        int x, y, z;
        x = rkx[d]; y = rky[d]; z = rkz[d];
        case (dir)
            0: x = (x + 1) % 8;
            1: x = (x + 7) % 8;
            2: y = (y + 1) % 8;
            3: y = (y + 7) % 8;
            4: z = (z + 1) % 8;
            default: z = (z + 7) % 8;
        endcase
        r = f;
        r[72]    = 1'b1;
        r[71:69] = 3'(z); r[68:66] = 3'(y); r[65:63] = 3'(x);
        r[62:60] = 3'(rkz[d]); r[59:57] = 3'(rky[d]); r[56:54] = 3'(rkx[d]);
        return r;
    endfunction

    task automatic idle_chk(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_in_ready"}, d, 73'(ir[d]), 73'd1);
            chk({tag, "_busy"}, d, 73'(bz[d]), 73'd0);
            chk({tag, "_local_valid"}, d, 73'(lv[d]), 73'd0);
            chk({tag, "_out_valid"}, d, 73'(ov[d]), 73'd0);
            chk({tag, "_out_flit"}, d, of[d], 73'd0);
            chk({tag, "_copies"}, d, 73'(cs[d]), 73'(cnt));
        end
    endtask

    // One complete transaction: offer f/m, stall local lst cycles and the
    // first out copy ost cycles, check every cycle until idle again.
    task automatic run(input string tag, input logic [72:0] f, input logic [5:0] m,
                       input int lst, input int ost);
        bit   bc;
        bit   isdup;
        int   dirs[$];
        int   lim;
        @(negedge clk);
        idle_chk({tag, "_pre"});
        in_flit = f; child_mask = m; in_valid = 1'b1;
        local_ready = (lst == 0); out_ready = (ost == 0);
`ifdef BCAST_DUP_FILTER_EN
        isdup = mkey_v && (mkey == {f[53:46], f[45:38]});
`else
        isdup = 1'b0;
`endif
        bc = f[72] && !isdup;
        if (f[72]) begin mkey = {f[53:46], f[45:38]}; mkey_v = 1'b1; end
        for (int i = 0; i < 6; i++) if (m[i]) dirs.push_back(i);
        @(negedge clk);
        in_valid = 1'b0;
        in_flit = {9'($urandom), 32'($urandom), 32'($urandom)};
        child_mask = 6'($urandom);
        if (!bc) begin
            idle_chk({tag, "_drop"});
            return;
        end
        for (int s = 0; s <= lst; s++) begin
            if (s > 0) @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                chk({tag, "_local_valid"}, d, 73'(lv[d]), 73'd1);
                chk({tag, "_local_flit"}, d, lf[d], f);
                chk({tag, "_local_out_valid"}, d, 73'(ov[d]), 73'd0);
                chk({tag, "_local_in_ready"}, d, 73'(ir[d]), 73'd0);
                chk({tag, "_local_busy"}, d, 73'(bz[d]), 73'd1);
            end
            local_ready = (s >= lst);
        end
        for (int i = 0; i < dirs.size(); i++) begin
            lim = (i == 0) ? ost : 0;
            for (int s = 0; s <= lim; s++) begin
                @(negedge clk);
                for (int d = 0; d < 2; d++) begin
                    chk({tag, "_out_valid"}, d, 73'(ov[d]), 73'd1);
                    chk({tag, "_out_flit"}, d, of[d], mcopy(f, dirs[i], d));
                    chk({tag, "_send_local_valid"}, d, 73'(lv[d]), 73'd0);
                    chk({tag, "_send_local_flit"}, d, lf[d], 73'd0);
                    chk({tag, "_send_in_ready"}, d, 73'(ir[d]), 73'd0);
                    chk({tag, "_send_copies"}, d, 73'(cs[d]), 73'(cnt));
                end
                out_ready = (i > 0 || s >= lim);
            end
            cnt++;
        end
        @(negedge clk);
        idle_chk({tag, "_post"});
        local_ready = 1'b1; out_ready = 1'b1;
    endtask

    function automatic logic [72:0] mkflit(input logic [7:0] ctx, input logic [7:0] tag,
                                           input logic [31:0] pay);
        logic [72:0] f;
        f = {9'($urandom), 32'($urandom), 32'($urandom)};
        f[72] = 1'b1;
        f[53:46] = ctx; f[45:38] = tag; f[31:0] = pay;
        return f;
    endfunction

    initial begin
        logic [72:0] f;
        // Reset: outputs quiet for 3 cycles, then in_ready immediately.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                chk("rst_in_ready", d, 73'(ir[d]), 73'd0);
                chk("rst_busy", d, 73'(bz[d]), 73'd0);
                chk("rst_local_valid", d, 73'(lv[d]), 73'd0);
                chk("rst_local_flit", d, lf[d], 73'd0);
                chk("rst_out_valid", d, 73'(ov[d]), 73'd0);
                chk("rst_out_flit", d, of[d], 73'd0);
                chk("rst_copies", d, 73'(cs[d]), 73'd0);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        idle_chk("rel");

        // Basic fan-out and wrap-around (instance b sits at (7,0,0)).
        run("basic", mkflit(8'h21, 8'h05, 32'h3F80_0000), 6'b000101, 0, 0);
        for (int d = 0; d < 2; d++) chk("basic_total", d, 73'(cs[d]), 73'd2);
        run("wrap", mkflit(8'h33, 8'h44, 32'hDEAD_BEEF), 6'b100010, 0, 0);
        // Backpressure on the first out copy, then on the local copy.
        run("bp_out", mkflit(8'h01, 8'h02, 32'h1234_5678), 6'b001001, 0, 5);
        run("bp_local", mkflit(8'h03, 8'h04, 32'h0BAD_F00D), 6'b110000, 3, 2);
        // Leaf and invalid flits.
        run("leaf", mkflit(8'h05, 8'h06, 32'h0000_0001), 6'b000000, 0, 0);
        f = mkflit(8'h07, 8'h08, 32'h0000_0002); f[72] = 1'b0;
        run("invalid", f, 6'b111111, 0, 0);
        // Same key twice.
        run("dup1", mkflit(8'h12, 8'h07, 32'hAAAA_0001), 6'b000001, 0, 0);
        run("dup2", mkflit(8'h12, 8'h07, 32'hAAAA_0002), 6'b000011, 0, 0);

        // Randomized transactions.
        for (int n = 0; n < 30; n++) begin
            f = {9'($urandom), 32'($urandom), 32'($urandom)};
            f[72] = ($urandom_range(0, 7) != 0);
            if (n % 5 == 4) begin f[53:46] = mkey[15:8]; f[45:38] = mkey[7:0]; end
            run("rand", f, 6'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
        end

        // Reset during SEND aborts and forgets pending copies.
        @(negedge clk);
        in_flit = mkflit(8'h55, 8'h66, 32'h0); child_mask = 6'b000011;
        in_valid = 1'b1; out_ready = 1'b0; local_ready = 1'b1;
        mkey = {8'h55, 8'h66}; mkey_v = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) chk("abort_in_send", d, 73'(ov[d]), 73'd1);
        rst = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("abort_out_valid", d, 73'(ov[d]), 73'd0);
            chk("abort_out_flit", d, of[d], 73'd0);
            chk("abort_busy", d, 73'(bz[d]), 73'd0);
            chk("abort_in_ready", d, 73'(ir[d]), 73'd0);
            chk("abort_copies", d, 73'(cs[d]), 73'd0);
        end
        rst = 1'b0; out_ready = 1'b1;
        cnt = '0; mkey_v = 1'b0;
        // Same key as the aborted flit: filter state was cleared by reset.
        run("post_abort_leaf", mkflit(8'h55, 8'h66, 32'h5), 6'b000000, 0, 0);
        run("post_abort", mkflit(8'h77, 8'h88, 32'h6), 6'b000100, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcast_fanout.md
# bcast_fanout

Broadcast fan-out unit for the MPI collective router: the downward half of the collective tree, complementing the upward reduction path. It accepts one 73-bit collective flit, which is either a completed reduction result or a root-issued broadcast. It delivers an unchanged copy to the local host port. It then emits one re-addressed copy per tree child, with dst set to the neighbour coordinate and src set to this rank, one at a time over a valid/ready link.

## Interface
- RANK_X, 0: this node's x coordinate (3 bits)
- RANK_Y, 0: this node's y coordinate (3 bits)
- RANK_Z, 0: this node's z coordinate (3 bits)
- FlitWidth, 73: flit width; field map:
  - valid 72
  - dst_z 71-69, dst_y 68-66, dst_x 65-63
  - src_z 62-60, src_y 59-57, src_x 56-54
  - contextId 53-46, tag 45-38
  - algtype 37-36, op 35-32
  - payload 31-0
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- in_flit  input  73  incoming flit
- in_valid  input  1  in_flit is valid
- in_ready  output  1  block can accept a flit
- child_mask  input  6  child directions, sampled with in_flit. Bit order: 0 +x, 1 -x, 2 +y, 3 -y, 4 +z, 5 -z
- local_flit  output  73  copy delivered to the host
- local_valid  output  1  local_flit is valid
- local_ready  input  1  host accepts the copy
- out_flit  output  73  copy sent to the network
- out_valid  output  1  out_flit is valid
- out_ready  input  1  network link accepts the copy
- busy  output  1  state is not IDLE
- copies_sent  output  16  count of completed out handshakes; wraps

## Operation
- States:
  - IDLE: in_ready=1 when rst is low.
  - LOCAL: local_valid=1.
  - SEND: out_valid=1.
- Accept condition: in_valid && in_ready at a rising edge.
- On accept:
  - If in_flit[72]=0, the flit is discarded and the state stays IDLE.
  - Otherwise the flit is latched into hold_flit, child_mask is latched into pending, and the state goes to LOCAL.
- LOCAL:
  - local_flit = hold_flit, unmodified.
  - On local_ready: go to SEND if pending≠0, otherwise go to IDLE.
- SEND:
  - sel = lowest set bit of pending.
  - out_flit = hold_flit with dst replaced by the neighbour in direction sel, and src = {RANK_Z,RANK_Y,RANK_X}.
  - All other fields are copied from hold_flit; valid = 1.
  - On out_ready: clear pending[sel] and increment copies_sent. If the cleared pending is 0, go to IDLE.
- Neighbour arithmetic is 3-bit modulo 8 per axis:
  - +x gives (RANK_X+1)&7.
  - -x gives (RANK_X-1)&7.
  - The same rule applies to y and z.
  - Non-selected axes keep the rank coordinate.
- Outputs are driven from registered state only. There is no combinational path from in_* to local_*/out_*.
- local_flit and out_flit are 0 whenever their respective valid is 0.
- Stability: while a valid is high and its ready is low, all corresponding outputs are held stable.

## Timing
- Reset values:
  - state IDLE, pending 0, hold_flit 0, copies_sent 0.
  - in_ready, local_valid, out_valid, busy all 0.
  - local_flit and out_flit 0.
- in_ready is 0 while rst is high and rises in the first cycle after rst falls.
- Accept at edge N gives local_valid=1 in cycle N+1.
- With k children and ready tied high:
  - local copy in cycle N+1.
  - out copies in cycles N+2 … N+1+k.
  - in_ready=1 in cycle N+2+k.
- Throughput: at most one out copy per cycle.
- Back-to-back flits are separated by at least one IDLE cycle.
- rst asserted in any state aborts the operation: pending copies are lost, and nothing further is emitted.
- A flit offered while busy is not accepted (in_ready=0). It must be held by the sender.

## Configuration
- BCAST_DUP_FILTER_EN defined:
  - The block keeps last_key={contextId,tag} plus a key_valid bit, both cleared by rst.
  - last_key/key_valid update on each accepted valid flit.
  - A flit with flit valid=1 whose key equals last_key while key_valid=1 is consumed (handshake completes), then dropped. No local or out copies are made, copies_sent is unchanged, and the state stays IDLE.
- Undefined: no filtering; every valid flit is broadcast.

## Test plan
- Reset check: hold rst 3 cycles → all outputs 0 during rst; in_ready=1 in the first cycle after release; busy=0.
- Basic fan-out: rank (1,1,1), flit payload 0x3F800000, tag 5, child_mask 6'b000101 → local_flit equals input in cycle N+1. Then out_flit has dst (2,1,1), src (1,1,1), then dst (1,2,1). copies_sent=2; in_ready returns in cycle N+4.
- Wrap-around: rank (7,0,0), child_mask 6'b100010 → out dst (6,0,0), then (7,0,7); payload/tag/contextId unchanged.
- Backpressure: out_ready low for 5 cycles in SEND → out_flit stable, in_ready=0, copies_sent not incremented until the handshake.
- Leaf and invalid: child_mask 0 → local copy only, then IDLE, copies_sent unchanged. Flit valid bit 0 → consumed, no outputs.
- Dup filter and reset: same contextId 0x12/tag 0x07 offered twice:
  - Macro on: second flit consumed silently.
  - Macro off: two broadcasts.
  - rst during SEND: out_valid=0 the next cycle and pending is cleared.
